srff_drv: RTL

//  Drives the S/R/enable inputs of the layer "busy" SR flag (srff_en) and checks its Q feedback.
//  On a start pulse it sets the flag, counts output pixels over a ROWS x COLS feature map,

---
 rtl/srff_drv_if.sv | 34 +++
 rtl/srff_drv.sv | 118 +++++++++++
 2 files changed

// File: rtl/srff_drv_if.sv
// Interface between the layer controller / busy SR flop and srff_drv.
// master = controller + flop side, slave = srff_drv.
interface srff_drv_if #(
  parameter int unsigned ROW_W = 5,
  parameter int unsigned COL_W = 5
);
  logic             srff_drv_start_i;
  logic             srff_drv_abort_i;
  logic             srff_drv_pix_i;
  logic             srff_drv_q_i;
  logic             srff_drv_err_clr_i;
  logic             srff_drv_S_o;
  logic             srff_drv_R_o;
  logic             srff_drv_en_o;
  logic [ROW_W-1:0] srff_drv_row_o;
  logic [COL_W-1:0] srff_drv_col_o;
  logic             srff_drv_done_o;
  logic             srff_drv_abrt_o;
  logic             srff_drv_err_o;

  modport master (
    output srff_drv_start_i, srff_drv_abort_i, srff_drv_pix_i,
           srff_drv_q_i, srff_drv_err_clr_i,
    input  srff_drv_S_o, srff_drv_R_o, srff_drv_en_o, srff_drv_row_o,
           srff_drv_col_o, srff_drv_done_o, srff_drv_abrt_o, srff_drv_err_o
  );

  modport slave (
    input  srff_drv_start_i, srff_drv_abort_i, srff_drv_pix_i,
           srff_drv_q_i, srff_drv_err_clr_i,
    output srff_drv_S_o, srff_drv_R_o, srff_drv_en_o, srff_drv_row_o,
           srff_drv_col_o, srff_drv_done_o, srff_drv_abrt_o, srff_drv_err_o
  );
endinterface

// File: rtl/srff_drv.sv
// Sequences S/R/enable of the layer busy SR flag over one ROWS x COLS frame,
// checks the flag's Q feedback and reports done/abort/sticky error.
module srff_drv #(
  parameter int unsigned ROWS  = 28,
  parameter int unsigned COLS  = 28,
  parameter int unsigned ROW_W = 5,
  parameter int unsigned COL_W = 5
) (
  input  logic      srff_drv_clk,
  input  logic      srff_drv_rst_b,
  srff_drv_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_RUN,
    ST_CLR,
    ST_CHK
  } state_e;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic             err_set;

  always_ff @(posedge srff_drv_clk or negedge srff_drv_rst_b) begin
    if (!srff_drv_rst_b) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    abort_d = abort_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.srff_drv_start_i) begin
          state_d = ST_SET;
          row_d   = '0;
          col_d   = '0;
          abort_d = 1'b0;
        end
      end
      ST_SET: begin
        if (bus.srff_drv_abort_i) begin
          state_d = ST_CLR;
          abort_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort beats a same-cycle pixel, so the counters freeze on abort.
        if (bus.srff_drv_abort_i) begin
          state_d = ST_CLR;
          abort_d = 1'b1;
        end else if (bus.srff_drv_pix_i) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_CLR;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_CLR:  state_d = ST_CHK;
      ST_CHK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error: start outside IDLE, Q low while running, Q still high after clear.
  always_comb begin
    err_set = (bus.srff_drv_start_i && (state_q != ST_IDLE)) ||
              ((state_q == ST_RUN) && !bus.srff_drv_q_i) ||
              ((state_q == ST_CHK) && bus.srff_drv_q_i);
    err_d   = bus.srff_drv_err_clr_i ? 1'b0 : (err_q | err_set);
  end

  always_comb begin
    logic s_set;
    logic s_clr;
    s_set               = (state_q == ST_SET);
    s_clr               = (state_q == ST_CLR);
    bus.srff_drv_S_o    = s_set;
    bus.srff_drv_R_o    = s_clr;
    bus.srff_drv_en_o   = s_set | s_clr;
    bus.srff_drv_row_o  = row_q;
    bus.srff_drv_col_o  = col_q;
    bus.srff_drv_done_o = (state_q == ST_CHK) && !abort_q;
    bus.srff_drv_abrt_o = (state_q == ST_CHK) && abort_q;
    bus.srff_drv_err_o  = err_q;
  end

endmodule
